// File: rtl/fft_common_pkg.sv
// ----------------------------------------------------------------------------
// fft_common_pkg
//   Shared definitions for the iterative FFT datapath blocks.
//   - EN_LEVEL_HIGH / EN_LEVEL_LOW : values for a block's EN_LEVEL parameter,
//     naming which level of EN means "advance".
//   - count_width(depth)           : width of an occupancy counter able to
//     hold every value 0..depth.
// ----------------------------------------------------------------------------
package fft_common_pkg;

    localparam bit EN_LEVEL_HIGH = 1'b1;
    localparam bit EN_LEVEL_LOW  = 1'b0;

    // Bits needed to represent 0..depth inclusive (never less than 1).
    function automatic int count_width(input int depth);
        if (depth < 1) begin
            return 1;
        end
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// ----------------------------------------------------------------------------
// pipe_stage
//   One slot of the elastic pipeline: a valid bit plus a data word.
//   When i_ADV is high the slot takes its predecessor's valid bit; the data
//   word is only overwritten when the incoming word is valid, so the data
//   register does not toggle while bubbles pass through.
//
//   Ports
//     CLK           clock, posedge
//     RST           asynchronous reset, active-low
//     i_FLUSH       synchronous clear of the valid bit (and data if RESET_DATA)
//     i_ADV         slot advances this cycle (load from predecessor)
//     i_VALID       predecessor valid bit
//     i_DATA        predecessor data word
//     o_VALID       slot valid bit
//     o_DATA        slot data word
//
//   RESET_DATA=1 : data cleared on reset and on flush.
//   RESET_DATA=0 : data register has no reset; it simply holds its last load.
// ----------------------------------------------------------------------------
module pipe_stage
    import fft_common_pkg::*;
#(
    parameter int BITNESS    = 16,
    parameter bit RESET_DATA = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_FLUSH,
    input  logic               i_ADV,
    input  logic               i_VALID,
    input  logic [BITNESS-1:0] i_DATA,
    output logic               o_VALID,
    output logic [BITNESS-1:0] o_DATA
);

    logic valid_q;
    logic [BITNESS-1:0] data_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_q <= 1'b0;
        end else if (i_FLUSH) begin
            valid_q <= 1'b0;
        end else if (i_ADV) begin
            valid_q <= i_VALID;
        end
    end

    generate
        if (RESET_DATA) begin : g_data_rst
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    data_q <= '0;
                end else if (i_FLUSH) begin
                    data_q <= '0;
                end else if (i_ADV && i_VALID) begin
                    data_q <= i_DATA;
                end
            end
        end else begin : g_data_norst
            // No reset on the data flop. RST still gates the load so that an
            // edge seen while reset is held cannot capture a new word.
            always_ff @(posedge CLK) begin
                if (RST && !i_FLUSH && i_ADV && i_VALID) begin
                    data_q <= i_DATA;
                end
            end
        end
    endgenerate

    assign o_VALID = valid_q;
    assign o_DATA  = data_q;

endmodule

// File: rtl/param_pipe_reg.sv
// ----------------------------------------------------------------------------
// param_pipe_reg
//   DEPTH-stage elastic pipeline register with per-stage valid bits,
//   bubble collapsing, global stall (EN), synchronous flush and a registered
//   occupancy count. Stage 0 is the input side, stage DEPTH-1 the output side.
//
//   Ports
//     CLK      clock, posedge
//     RST      asynchronous reset, active-low
//     EN       global advance enable; active level set by EN_LEVEL
//     i_FLUSH  synchronous flush, active-high, wins over EN and transfers
//     i_VALID  input word valid
//     o_READY  pipeline accepts input this cycle
//     i_DATA   input word
//     o_VALID  output word valid (valid bit of stage DEPTH-1)
//     i_READY  downstream accepts output
//     o_DATA   output word (data of stage DEPTH-1)
//     o_COUNT  number of valid stages, 0..DEPTH
//
//   Handshake: a word moves across an interface on a rising CLK edge when
//   VALID and READY are both high in that cycle (and EN is active). A source
//   holds VALID and DATA steady until that edge; READY never depends on
//   VALID, so o_READY is a function of i_READY, EN and the stage valid bits
//   only. There is no combinational path from i_VALID or i_DATA to any
//   output. A flush does not lower o_READY: a word offered in the flush
//   cycle counts as taken by the source and is discarded here.
// ----------------------------------------------------------------------------
module param_pipe_reg
    import fft_common_pkg::*;
#(
    parameter int BITNESS    = 16,
    parameter int DEPTH      = 2,
    parameter bit RESET_DATA = 1'b1,
    parameter bit EN_LEVEL   = EN_LEVEL_HIGH
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          EN,
    input  logic                          i_FLUSH,
    input  logic                          i_VALID,
    output logic                          o_READY,
    input  logic [BITNESS-1:0]            i_DATA,
    output logic                          o_VALID,
    input  logic                          i_READY,
    output logic [BITNESS-1:0]            o_DATA,
    output logic [count_width(DEPTH)-1:0] o_COUNT
);

    localparam int CW = count_width(DEPTH);

    logic               en_act;
    logic [DEPTH-1:0]   adv;
    logic               v      [DEPTH];
    logic [BITNESS-1:0] d      [DEPTH];
    logic               v_prev [DEPTH];
    logic [BITNESS-1:0] d_prev [DEPTH];
    logic [CW-1:0]      cnt_nxt;
    logic [CW-1:0]      cnt_q;

    assign en_act = (EN == EN_LEVEL);

    // Advance chain. adv[k] = en_act & (!v[k] | adv[k+1]) with the tail fed
    // by i_READY; unrolled, a stage advances when any stage at or beyond it
    // is empty or the output is being taken. That is what lets an empty
    // stage swallow its predecessor while the output end is stalled.
    always_comb begin : adv_chain
        logic room;
        room = i_READY;
        adv  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            room   = room | ~v[k];
            adv[k] = en_act & room;
        end
    end

    assign o_READY = adv[0];

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign v_prev[k] = i_VALID;
                assign d_prev[k] = i_DATA;
            end else begin : g_body
                assign v_prev[k] = v[k-1];
                assign d_prev[k] = d[k-1];
            end

            pipe_stage #(
                .BITNESS    (BITNESS),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .CLK     (CLK),
                .RST     (RST),
                .i_FLUSH (i_FLUSH),
                .i_ADV   (adv[k]),
                .i_VALID (v_prev[k]),
                .i_DATA  (d_prev[k]),
                .o_VALID (v[k]),
                .o_DATA  (d[k])
            );
        end
    endgenerate

    // Occupancy is the popcount of the valid bits the stages will hold after
    // this edge, registered so it changes on the same edge as the bits.
    always_comb begin : count_next
        logic nv;
        cnt_nxt = '0;
        for (int j = 0; j < DEPTH; j++) begin
            nv      = i_FLUSH ? 1'b0 : (adv[j] ? v_prev[j] : v[j]);
            cnt_nxt = cnt_nxt + CW'(nv);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    assign o_VALID = v[DEPTH-1];
    assign o_DATA  = d[DEPTH-1];
    assign o_COUNT = cnt_q;

endmodule

// File: tb/tb_param_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_param_pipe_reg
//   Two instances share one stimulus stream:
//     u_dut0 : DEPTH=3, RESET_DATA=1, EN active-high
//     u_dut1 : DEPTH=4, RESET_DATA=0, EN active-low (driven with ~en_act)
//   A word-level model (slots that march toward the output, each word moving
//   when a free slot lies ahead or the output is taken) plus an in-order
//   expected queue per instance are compared against the DUTs on every
//   falling edge. Directed literal checks pin the model on the scenarios.
// ----------------------------------------------------------------------------
module tb_param_pipe_reg;
    import fft_common_pkg::*;

    localparam int W   = 16;
    localparam int D0  = 3;
    localparam int D1  = 4;
    localparam int CW0 = count_width(D0);
    localparam int CW1 = count_width(D1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         en_act  = 1'b1;
    logic         i_flush = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [W-1:0] i_data  = '0;

    logic           en0, en1;
    logic           rdy0, vld0, rdy1, vld1;
    logic [W-1:0]   dat0, dat1;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;

    assign en0 = en_act;
    assign en1 = ~en_act;

    param_pipe_reg #(
        .BITNESS(W), .DEPTH(D0), .RESET_DATA(1'b1), .EN_LEVEL(EN_LEVEL_HIGH)
    ) u_dut0 (
        .CLK(clk), .RST(rst), .EN(en0), .i_FLUSH(i_flush),
        .i_VALID(i_valid), .o_READY(rdy0), .i_DATA(i_data),
        .o_VALID(vld0), .i_READY(i_ready), .o_DATA(dat0), .o_COUNT(cnt0)
    );

    param_pipe_reg #(
        .BITNESS(W), .DEPTH(D1), .RESET_DATA(1'b0), .EN_LEVEL(EN_LEVEL_LOW)
    ) u_dut1 (
        .CLK(clk), .RST(rst), .EN(en1), .i_FLUSH(i_flush),
        .i_VALID(i_valid), .o_READY(rdy1), .i_DATA(i_data),
        .o_VALID(vld1), .i_READY(i_ready), .o_DATA(dat1), .o_COUNT(cnt1)
    );

    // ---------------- model + scoreboard ----------------
    logic         mv [2][4];
    logic [W-1:0] md [2][4];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int depth_of(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int model_count(input int i);
        int c = 0;
        for (int k = 0; k < depth_of(i); k++) c += (mv[i][k] ? 1 : 0);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) begin
                mv[i][k] = 1'b0;
                md[i][k] = '0;
            end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_step(input int i);
        int           dep;
        bit           hole;
        bit           acc;
        logic         nv [4];
        logic [W-1:0] nd [4];
        dep = depth_of(i);
        acc = i_valid && ((model_count(i) < dep) || i_ready);
        for (int k = 0; k < 4; k++) begin
            nv[k] = 1'b0;
            nd[k] = md[i][k];
        end
        for (int k = dep - 1; k >= 0; k--) begin
            if (mv[i][k]) begin
                hole = 1'b0;
                for (int j = k + 1; j < dep; j++) if (!mv[i][j]) hole = 1'b1;
                if (hole || i_ready) begin
                    if (k == dep - 1) begin
                        if (i == 0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
                        if (i == 1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
                    end else begin
                        nv[k+1] = 1'b1;
                        nd[k+1] = md[i][k];
                    end
                end else begin
                    nv[k] = 1'b1;
                end
            end
        end
        if (acc) begin
            nv[0] = 1'b1;
            nd[0] = i_data;
            if (i == 0) exp_q0.push_back(i_data);
            else        exp_q1.push_back(i_data);
        end
        for (int k = 0; k < 4; k++) begin
            mv[i][k] = nv[k];
            md[i][k] = nd[k];
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst || i_flush) begin
                model_clear();
            end else if (en_act) begin
                model_step(0);
                model_step(1);
            end
        end
    end

    task automatic compare_inst(input int i);
        int           dep;
        int           cnt;
        logic         lastv;
        logic         exp_rdy;
        logic         out_xfer;
        logic [W-1:0] front;
        dep      = depth_of(i);
        cnt      = model_count(i);
        lastv    = mv[i][dep-1];
        exp_rdy  = en_act && ((cnt < dep) || i_ready);
        out_xfer = rst && !i_flush && en_act && lastv && i_ready;
        if (i == 0) begin
            check("cyc o_VALID0", 32'(vld0), 32'(lastv));
            check("cyc o_COUNT0", 32'(cnt0), 32'(cnt));
            check("cyc o_READY0", 32'(rdy0), 32'(exp_rdy));
            if (lastv) check("cyc o_DATA0", 32'(dat0), 32'(md[0][dep-1]));
            if (out_xfer) begin
                front = (exp_q0.size() > 0) ? exp_q0[0] : '1;
                check("order o_DATA0", 32'(dat0), 32'(front));
            end
        end else begin
            check("cyc o_VALID1", 32'(vld1), 32'(lastv));
            check("cyc o_COUNT1", 32'(cnt1), 32'(cnt));
            check("cyc o_READY1", 32'(rdy1), 32'(exp_rdy));
            if (lastv) check("cyc o_DATA1", 32'(dat1), 32'(md[1][dep-1]));
            if (out_xfer) begin
                front = (exp_q1.size() > 0) ? exp_q1[0] : '1;
                check("order o_DATA1", 32'(dat1), 32'(front));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_inst(0);
            compare_inst(1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        i_ready = r;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        drive(1'b0, '0, 1'b1);
        repeat (2) tick();
        #1;
        check("rst o_VALID0", 32'(vld0), 0);
        check("rst o_COUNT0", 32'(cnt0), 0);
        check("rst o_DATA0",  32'(dat0), 0);
        check("rst o_READY0", 32'(rdy0), 1);
        check("rst o_VALID1", 32'(vld1), 0);
        check("rst o_COUNT1", 32'(cnt1), 0);
        rst = 1'b1;
        tick();

        // fill and stream out
        drive(1'b1, 16'h0011, 1'b1); tick();
        check("fill cnt0 e1", 32'(cnt0), 1);
        check("fill vld0 e1", 32'(vld0), 0);
        drive(1'b1, 16'h0022, 1'b1); tick();
        check("fill vld0 e2", 32'(vld0), 0);
        drive(1'b1, 16'h0033, 1'b1); tick();
        check("fill vld0 e3", 32'(vld0), 1);
        check("fill dat0 e3", 32'(dat0), 32'h0011);
        check("fill cnt0 e3", 32'(cnt0), 3);
        drive(1'b0, '0, 1'b1); tick();
        check("fill dat0 e4", 32'(dat0), 32'h0022);
        check("fill vld1 e4", 32'(vld1), 1);
        check("fill dat1 e4", 32'(dat1), 32'h0011);
        tick();
        check("fill dat0 e5", 32'(dat0), 32'h0033);
        tick();
        check("fill vld0 e6", 32'(vld0), 0);
        repeat (2) tick();

        // backpressure until full
        drive(1'b1, 16'h0041, 1'b0); tick();
        drive(1'b1, 16'h0042, 1'b0); tick();
        drive(1'b1, 16'h0043, 1'b0); tick();
        check("bp rdy0 full", 32'(rdy0), 0);
        check("bp cnt0 full", 32'(cnt0), 3);
        check("bp dat0 full", 32'(dat0), 32'h0041);
        check("bp rdy1 room", 32'(rdy1), 1);
        drive(1'b1, 16'h0044, 1'b0); tick();
        check("bp cnt0 held", 32'(cnt0), 3);
        check("bp cnt1 full", 32'(cnt1), 4);
        check("bp rdy1 full", 32'(rdy1), 0);
        drive(1'b1, 16'h0044, 1'b1);
        #1;
        check("bp rdy0 comb", 32'(rdy0), 1);
        tick();
        check("bp shift cnt0", 32'(cnt0), 3);
        check("bp shift dat0", 32'(dat0), 32'h0042);
        check("bp shift cnt1", 32'(cnt1), 4);
        drive(1'b0, '0, 1'b1);
        tick(); check("bp drain dat0 a", 32'(dat0), 32'h0043);
        tick(); check("bp drain dat0 b", 32'(dat0), 32'h0044);
        tick(); check("bp drain cnt0", 32'(cnt0), 0);
        tick(); check("bp drain cnt1", 32'(cnt1), 0);

        // bubble collapse with the output stalled
        drive(1'b1, 16'h00A1, 1'b0); tick();
        drive(1'b0, '0, 1'b0); tick(); tick();
        drive(1'b1, 16'h00A2, 1'b0); tick();
        drive(1'b0, '0, 1'b0); tick(); tick();
        check("bub cnt1", 32'(cnt1), 2);
        check("bub vld1", 32'(vld1), 1);
        check("bub dat1", 32'(dat1), 32'h00A1);
        check("bub rdy1", 32'(rdy1), 1);
        check("bub cnt0", 32'(cnt0), 2);
        check("bub rdy0", 32'(rdy0), 1);
        drive(1'b0, '0, 1'b1); tick();
        check("bub next dat1", 32'(dat1), 32'h00A2);
        check("bub next vld1", 32'(vld1), 1);
        check("bub next dat0", 32'(dat0), 32'h00A2);
        tick();
        check("bub empty cnt1", 32'(cnt1), 0);

        // global stall mid-stream
        drive(1'b1, 16'h0051, 1'b1); tick();
        drive(1'b1, 16'h0052, 1'b1); tick();
        drive(1'b1, 16'h0053, 1'b1); tick();
        drive(1'b1, 16'h0054, 1'b1);
        en_act = 1'b0;
        #1;
        check("stall rdy0", 32'(rdy0), 0);
        check("stall rdy1", 32'(rdy1), 0);
        for (int n = 0; n < 5; n++) begin
            tick();
            check("stall cnt0", 32'(cnt0), 3);
            check("stall dat0", 32'(dat0), 32'h0051);
            check("stall vld0", 32'(vld0), 1);
            check("stall cnt1", 32'(cnt1), 3);
        end
        en_act = 1'b1;
        tick();
        check("resume dat0", 32'(dat0), 32'h0052);
        check("resume cnt0", 32'(cnt0), 3);
        check("resume dat1", 32'(dat1), 32'h0051);
        check("resume cnt1", 32'(cnt1), 4);
        drive(1'b0, '0, 1'b1);
        repeat (4) tick();
        check("stall drain cnt0", 32'(cnt0), 0);
        check("stall drain cnt1", 32'(cnt1), 0);

        // flush drops the word offered in the same cycle
        drive(1'b1, 16'h0061, 1'b0); tick();
        drive(1'b1, 16'h0062, 1'b0); tick();
        drive(1'b1, 16'h0063, 1'b0); tick();
        check("fl pre cnt0", 32'(cnt0), 3);
        drive(1'b1, 16'hBEEF, 1'b0);
        i_flush = 1'b1;
        #1;
        check("fl rdy1 ungated", 32'(rdy1), 1);
        tick();
        i_flush = 1'b0;
        check("fl vld0", 32'(vld0), 0);
        check("fl cnt0", 32'(cnt0), 0);
        check("fl dat0", 32'(dat0), 0);
        check("fl vld1", 32'(vld1), 0);
        check("fl cnt1", 32'(cnt1), 0);
        drive(1'b0, '0, 1'b1);
        repeat (5) tick();
        check("fl no beef vld0", 32'(vld0), 0);
        check("fl no beef vld1", 32'(vld1), 0);

        // asynchronous reset with full pipes
        drive(1'b1, 16'h0071, 1'b0); tick();
        drive(1'b1, 16'h0072, 1'b0); tick();
        drive(1'b1, 16'h0073, 1'b0); tick();
        drive(1'b1, 16'h0074, 1'b0); tick();
        check("ar pre cnt1", 32'(cnt1), 4);
        check("ar pre dat1", 32'(dat1), 32'h0071);
        drive(1'b0, '0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("ar vld0", 32'(vld0), 0);
        check("ar cnt0", 32'(cnt0), 0);
        check("ar dat0", 32'(dat0), 0);
        check("ar rdy0", 32'(rdy0), 1);
        check("ar vld1", 32'(vld1), 0);
        check("ar cnt1", 32'(cnt1), 0);
        check("ar dat1 kept", 32'(dat1), 32'h0071);
        check("ar rdy1", 32'(rdy1), 1);
        tick();
        check("ar hold dat1", 32'(dat1), 32'h0071);
        rst = 1'b1;

        // first transfer after reset sees an empty pipe
        drive(1'b1, 16'h0081, 1'b1); tick();
        check("post cnt0", 32'(cnt0), 1);
        drive(1'b0, '0, 1'b1); tick();
        check("post vld0 n+1", 32'(vld0), 0);
        tick();
        check("post vld0 n+2", 32'(vld0), 1);
        check("post dat0 n+2", 32'(dat0), 32'h0081);
        check("post vld1 n+2", 32'(vld1), 0);
        tick();
        check("post vld1 n+3", 32'(vld1), 1);
        check("post dat1 n+3", 32'(dat1), 32'h0081);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
